pico_bus_xbar_1n: RTL and testbench

- Parametrised successor to the fixed 1-to-4 PicoRV32 native-bus mux; routes one master port to NS slave ports.
- Adds behaviour the combinational mux lacks:
  - registered request/response stages for timing closure;
  - priority address decode over packed base/mask arrays;
  - default-slave error response for unmapped addresses;
  - watchdog timeout for slaves that never respond;
  - sticky error reporting.
- Sits between the core (or an upstream xbar) and its peripherals.
- Replaces tied-off regions such as a constant-ready Wishbone window.

---
 rtl/pico_bus_pkg.sv | 23 ++
 rtl/pico_addr_decode.sv | 26 ++
 rtl/pico_bus_xbar_1n.sv | 181 ++++++++++++++++++
 tb/tb_pico_bus_xbar_1n.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pico_bus_pkg.sv
// Shared types and default SoC memory map for the PicoRV32 native-bus crossbar.
package pico_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_ERROR,
    ST_RESP
  } xbar_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  localparam logic [31:0] MAP_FLASH_BASE  = 32'h0000_0000;
  localparam logic [31:0] MAP_SRAM_BASE   = 32'h4000_0000;
  localparam logic [31:0] MAP_PERIPH_BASE = 32'h8000_0000;
  localparam logic [31:0] MAP_WB_BASE     = 32'hC000_0000;
  localparam logic [31:0] MAP_REGION_MASK = 32'hC000_0000;

  // Slave 0 sits in the least significant word of the packed map.
  localparam logic [127:0] SOC_MAP_BASE = {MAP_WB_BASE, MAP_PERIPH_BASE, MAP_SRAM_BASE, MAP_FLASH_BASE};
  localparam logic [127:0] SOC_MAP_MASK = {4{MAP_REGION_MASK}};

endpackage

// File: rtl/pico_addr_decode.sv
// Combinational base/mask address decoder; lowest-index match wins.
module pico_addr_decode
  import pico_bus_pkg::*;
#(
  parameter int                NS         = 4,
  parameter logic [NS*32-1:0]  SLAVE_BASE = SOC_MAP_BASE,
  parameter logic [NS*32-1:0]  SLAVE_MASK = SOC_MAP_MASK
) (
  input  logic [31:0]   addr,
  output logic [NS-1:0] sel,
  output logic          miss
);

  logic [NS-1:0] hit;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_hit
      assign hit[gi] = ((addr ^ SLAVE_BASE[32*gi +: 32]) & SLAVE_MASK[32*gi +: 32]) == 32'd0;
    end
  endgenerate

  // Isolate the lowest set bit to resolve overlapping regions.
  assign sel  = hit & (~hit + NS'(1));
  assign miss = ~|hit;

endmodule

// File: rtl/pico_bus_xbar_1n.sv
// One master to NS slaves on the PicoRV32 native bus, with registered stages,
// default-slave error responses, a response watchdog and sticky error reporting.
module pico_bus_xbar_1n
  import pico_bus_pkg::*;
#(
  parameter int                NS             = 4,
  parameter logic [NS*32-1:0]  SLAVE_BASE     = SOC_MAP_BASE,
  parameter logic [NS*32-1:0]  SLAVE_MASK     = SOC_MAP_MASK,
  parameter int                TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]       ERR_RDATA      = ERR_RDATA_DEFAULT,
  parameter int                ERR_CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  output logic [31:0]          m_rdata,
  output logic [NS-1:0]        s_valid,
  input  logic [NS-1:0]        s_ready,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic [NS*32-1:0]     s_rdata,
  output logic                 bus_err,
  output logic [31:0]          err_addr,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  xbar_state_e          state_reg, state_next;
  logic [NS-1:0]        sel_reg, sel_next;
  logic [NS-1:0]        s_valid_reg, s_valid_next;
  logic [31:0]          s_addr_reg, s_addr_next;
  logic [31:0]          s_wdata_reg, s_wdata_next;
  logic [3:0]           s_wstrb_reg, s_wstrb_next;
  logic [31:0]          m_rdata_reg, m_rdata_next;
  logic                 m_ready_reg, m_ready_next;
  logic                 bus_err_reg, bus_err_next;
  logic [31:0]          err_addr_reg, err_addr_next;
  logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;
  logic [TW-1:0]        tmo_cnt_reg, tmo_cnt_next;

  logic [NS-1:0]        dec_sel;
  logic                 dec_miss;
  logic                 sel_ready;
  logic [31:0]          sel_rdata;
  logic                 err_event;

  pico_addr_decode #(
    .NS         (NS),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr (m_addr),
    .sel  (dec_sel),
    .miss (dec_miss)
  );

  // Only the latched slave may complete the transaction.
  assign sel_ready = |(s_ready & sel_reg);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_reg[i]) sel_rdata = sel_rdata | s_rdata[32*i +: 32];
    end
  end

  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    s_valid_next  = s_valid_reg;
    s_addr_next   = s_addr_reg;
    s_wdata_next  = s_wdata_reg;
    s_wstrb_next  = s_wstrb_reg;
    m_rdata_next  = m_rdata_reg;
    m_ready_next  = 1'b0;
    bus_err_next  = 1'b0;
    err_addr_next = err_addr_reg;
    err_cnt_next  = err_cnt_reg;
    tmo_cnt_next  = tmo_cnt_reg;
    err_event     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        tmo_cnt_next = '0;
        if (m_valid) begin
          s_addr_next  = m_addr;
          s_wdata_next = m_wdata;
          s_wstrb_next = m_wstrb;
          sel_next     = dec_sel;
          if (dec_miss) begin
            state_next = ST_ERROR;
          end else begin
            state_next   = ST_ACTIVE;
            s_valid_next = dec_sel;
          end
        end
      end
      ST_ACTIVE: begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        if (sel_ready) begin
          m_rdata_next = sel_rdata;
          s_valid_next = '0;
          m_ready_next = 1'b1;
          state_next   = ST_RESP;
        end else if (TMO_EN && tmo_cnt_reg == TMO_LAST) begin
          m_rdata_next = ERR_RDATA;
          s_valid_next = '0;
          m_ready_next = 1'b1;
          err_event    = 1'b1;
          state_next   = ST_RESP;
        end
      end
      ST_ERROR: begin
        m_rdata_next = ERR_RDATA;
        m_ready_next = 1'b1;
        err_event    = 1'b1;
        state_next   = ST_RESP;
      end
      ST_RESP: begin
        tmo_cnt_next = '0;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    if (err_event) begin
      bus_err_next  = 1'b1;
      err_addr_next = s_addr_reg;
      if (err_cnt_reg != '1) err_cnt_next = err_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      sel_reg      <= '0;
      s_valid_reg  <= '0;
      s_addr_reg   <= '0;
      s_wdata_reg  <= '0;
      s_wstrb_reg  <= '0;
      m_rdata_reg  <= '0;
      m_ready_reg  <= 1'b0;
      bus_err_reg  <= 1'b0;
      err_addr_reg <= '0;
      err_cnt_reg  <= '0;
      tmo_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      s_valid_reg  <= s_valid_next;
      s_addr_reg   <= s_addr_next;
      s_wdata_reg  <= s_wdata_next;
      s_wstrb_reg  <= s_wstrb_next;
      m_rdata_reg  <= m_rdata_next;
      m_ready_reg  <= m_ready_next;
      bus_err_reg  <= bus_err_next;
      err_addr_reg <= err_addr_next;
      err_cnt_reg  <= err_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
    end
  end

  assign m_ready  = m_ready_reg;
  assign m_rdata  = m_rdata_reg;
  assign s_valid  = s_valid_reg;
  assign s_addr   = s_addr_reg;
  assign s_wdata  = s_wdata_reg;
  assign s_wstrb  = s_wstrb_reg;
  assign bus_err  = bus_err_reg;
  assign err_addr = err_addr_reg;
  assign err_cnt  = err_cnt_reg;

endmodule

// File: tb/tb_pico_bus_xbar_1n.sv
// Randomized scoreboard bench for pico_bus_xbar_1n: five overlapping slave
// regions plus an unmapped hole, short watchdog, reset and saturation cases.
module tb_pico_bus_xbar_1n;

  localparam int NS  = 5;
  localparam int T   = 8;
  localparam int ECW = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  // s0 0x0-0x3, s1 0x4-0x7, s2 0x8-0xB, s3 0xC only, s4 0xC-0xD (loses 0xC to s3), 0xE-0xF unmapped
  localparam logic [NS*32-1:0] BASE = {32'hC000_0000, 32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASK = {32'hE000_0000, 32'hF000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000};

  logic [31:0] map_base [NS] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'hC000_0000};
  logic [31:0] map_mask [NS] = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hF000_0000, 32'hE000_0000};

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           m_valid = 1'b0;
  logic           m_ready;
  logic [31:0]    m_addr = '0;
  logic [31:0]    m_wdata = '0;
  logic [3:0]     m_wstrb = '0;
  logic [31:0]    m_rdata;
  logic [NS-1:0]  s_valid;
  logic [NS-1:0]  s_ready = '0;
  logic [31:0]    s_addr;
  logic [31:0]    s_wdata;
  logic [3:0]     s_wstrb;
  logic [NS*32-1:0] s_rdata = '0;
  logic           bus_err;
  logic [31:0]    err_addr;
  logic [ECW-1:0] err_cnt;

  pico_bus_xbar_1n #(
    .NS(NS), .SLAVE_BASE(BASE), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(T), .ERR_RDATA(ERRD), .ERR_CNT_W(ECW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .bus_err(bus_err), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]    addr;
    logic [31:0]    rdata;
    logic           err;
    int             lat;
    logic [31:0]    eaddr;
    logic [ECW-1:0] ecnt;
    int             issue;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passes = 0;
  int txn_no = 0;

  logic [31:0] mdl_eaddr = '0;
  int          mdl_ecnt  = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // First matching region in index order, -1 when nothing claims the address.
  function automatic int ref_slave(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if (((a ^ map_base[i]) & map_mask[i]) == 32'd0) return i;
    end
    return -1;
  endfunction

  function automatic logic [NS*32-1:0] rand_rdata();
    logic [NS*32-1:0] r;
    for (int i = 0; i < NS; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // d: slave asserts ready d cycles after s_valid first appears (d >= T never beats the watchdog).
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input int d, input logic [31:0] rdata);
    int slv, rel, sv_cnt, exp_sv, stop_rel;
    bit seen, tmo;
    exp_t e;
    logic [NS-1:0] onehot, rdy;
    slv      = ref_slave(addr);
    tmo      = (slv >= 0) && (d >= T);
    exp_sv   = (slv < 0) ? 0 : (tmo ? T : d + 1);
    stop_rel = (slv < 0) ? 0 : d + 1;
    e.addr   = addr;
    e.err    = (slv < 0) || tmo;
    e.rdata  = e.err ? ERRD : rdata;
    e.lat    = (slv < 0) ? 2 : (tmo ? T + 1 : d + 2);
    if (e.err) begin
      mdl_eaddr = addr;
      if (mdl_ecnt < (1 << ECW) - 1) mdl_ecnt++;
    end
    e.eaddr = mdl_eaddr;
    e.ecnt  = ECW'(mdl_ecnt);
    onehot  = '0;
    if (slv >= 0) onehot[slv] = 1'b1;

    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = addr;
    m_wdata = wdata;
    m_wstrb = wstrb;
    e.issue = cyc;
    sb.push_back(e);

    seen = 0; sv_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      rel = cyc - e.issue;
      if (s_valid != '0) sv_cnt++;
      if (rel == 1 && slv >= 0) begin
        check("s_valid_sel", 96'(s_valid), 96'(onehot));
        check("s_bus", 96'({s_addr, s_wdata, s_wstrb}), 96'({addr, wdata, wstrb}));
      end
      if (m_ready) begin
        seen = 1;
        m_valid = 1'b0;
      end
      rdy = NS'($urandom) & ~onehot;
      if (slv >= 0 && rel == d + 1) rdy = rdy | onehot;
      s_ready = rdy;
      s_rdata = rand_rdata();
      if (slv >= 0) s_rdata[32*slv +: 32] = rdata;
      if (seen && rel >= stop_rel) break;
    end
    check("m_ready_seen", 96'(seen), 96'(1));
    check("s_valid_cycles", 96'(sv_cnt), 96'(exp_sv));
    @(negedge clk);
    s_ready = '0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Response monitor: pops the oldest expectation whenever the master sees m_ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && m_ready) begin
        if (sb.size() == 0) begin
          check("spurious_m_ready", 96'(m_ready), 96'(0));
        end else begin
          e = sb.pop_front();
          txn_no++;
          $display("txn %0d addr=%h rdata=%h bus_err=%b lat=%0d err_cnt=%0d",
                   txn_no, e.addr, m_rdata, bus_err, cyc - e.issue, err_cnt);
          check("m_rdata", 96'(m_rdata), 96'(e.rdata));
          check("bus_err", 96'(bus_err), 96'(e.err));
          check("latency", 96'(cyc - e.issue), 96'(e.lat));
          check("err_addr", 96'(err_addr), 96'(e.eaddr));
          check("err_cnt", 96'(err_cnt), 96'(e.ecnt));
        end
      end else if (resetn && bus_err) begin
        check("bus_err_without_ready", 96'(bus_err), 96'(0));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 96'({m_ready, bus_err, s_valid}), 96'(0));
    check({tag, "_data"}, 96'({m_rdata, s_addr, s_wdata}), 96'(0));
    check({tag, "_err"}, 96'({s_wstrb, err_addr, err_cnt}), 96'(0));
  endtask

  initial begin
    int d;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;

    // Directed: read slave 1, write slave 3, overlap to slave 4, watchdog, ready on the last watchdog cycle, miss.
    run_txn(32'h4000_0010, 32'h0, 4'b0000, 2, 32'h1234_5678);
    run_txn(32'hC000_0004, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0BAD_F00D);
    run_txn(32'hD000_0040, 32'h1111_2222, 4'b1111, 0, 32'h5555_AAAA);
    run_txn(32'h8000_0100, 32'h0, 4'b0000, T + 2, 32'h7777_7777);
    run_txn(32'h0000_0200, 32'h0, 4'b0000, T - 1, 32'hCAFE_0001);
    run_txn(32'hE000_0000, 32'h0, 4'b0000, 0, 32'h0);

    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      d = $urandom_range(0, T + 3);
      run_txn(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom), d, $urandom);
    end

    // Reset while a transaction is in ACTIVE: abandoned, outputs clear at once.
    @(negedge clk);
    m_valid = 1'b1;
    m_addr  = 32'h4000_0020;
    m_wdata = 32'h0;
    m_wstrb = 4'b0000;
    repeat (3) @(negedge clk);
    check("pre_reset_active", 96'(s_valid), 96'(5'b00010));
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    m_valid = 1'b0;
    resetn  = 1'b1;
    mdl_eaddr = '0;
    mdl_ecnt  = 0;
    run_txn(32'h4000_0020, 32'h0, 4'b0000, 1, 32'h600D_0000);

    for (int n = 0; n < 300; n++) begin
      a = {4'hE | 4'($urandom_range(0, 1)), 28'($urandom)};
      run_txn(a, $urandom, 4'b0000, 0, 32'h0);
    end
    check("err_cnt_saturated", 96'(err_cnt), 96'(255));

    for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
    check("scoreboard_drain", 96'(sb.size()), 96'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, %0d/%0d so far", passes, checks);
    $fatal(1, "timeout");
  end

endmodule
